// File: rtl/cpen391_pushbutton_debouncer.sv
// Debounces the raw KEY pads. It produces a clean active-high level bus for the
// PushButtons PIO, plus single-cycle press/release pulses.
// Each button passes through a 2-flop synchroniser and then a per-button
// stability counter.
module cpen391_pushbutton_debouncer #(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] key_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    localparam int unsigned CW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BUTTONS-1:0] RELEASED = {NUM_BUTTONS{ACTIVE_LOW}};

    // A button is PENDING while its synchronised input disagrees with the
    // accepted level. The accepted level itself serves as the state memory.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] pressed_s;
    logic [NUM_BUTTONS-1:0] level_next;
    logic [NUM_BUTTONS-1:0] press_next;
    logic [NUM_BUTTONS-1:0] release_next;
    logic [CW-1:0]          count      [NUM_BUTTONS];
    logic [CW-1:0]          count_next [NUM_BUTTONS];
    state_t                 state      [NUM_BUTTONS];

    // Per-button classification and next-value computation.
    always_comb begin
        pressed_s    = sync2 ^ RELEASED;
        level_next   = btn_level;
        press_next   = '0;
        release_next = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            count_next[i] = '0;
            state[i]      = (pressed_s[i] != btn_level[i]) ? PENDING : STABLE;
            case (state[i])
                STABLE: begin
                    count_next[i] = '0;
                end
                PENDING: begin
                    if (count[i] == LAST) begin
                        level_next[i]   = pressed_s[i];
                        press_next[i]   = pressed_s[i];
                        release_next[i] = ~pressed_s[i];
                        count_next[i]   = '0;
                    end else begin
                        count_next[i] = count[i] + CW'(1);
                    end
                end
                default: begin
                    count_next[i] = '0;
                end
            endcase
        end
    end

    // Synchroniser, counters and registered outputs. On reset the sync flops
    // load the released level, so a held key is re-qualified from scratch.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= RELEASED;
            sync2       <= RELEASED;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                count[i] <= count_next[i];
            end
        end
    end

endmodule

// File: tb/tb_cpen391_pushbutton_debouncer.sv
// Bench for the pushbutton debouncer.
// A reference model predicts the outputs after each rising edge and pushes
// them into a queue. A monitor pops one entry each falling edge and compares.
module tb_cpen391_pushbutton_debouncer;

    localparam int NB = 4;
    localparam int D  = 8;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic [NB-1:0] key_raw = '1;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpen391_pushbutton_debouncer #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } exp_t;

    exp_t expq[$];

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // Reference model. The pressed value seen at an edge is the key value sampled
    // two edges earlier; reset refills that delay with the released value.
    // A button takes a new value once the last D seen values all differ from
    // its accepted level.
    bit            pipe0 [NB];
    bit            pipe1 [NB];
    bit            win   [NB][$];
    logic [NB-1:0] m_level = '0;

    always @(posedge clk) begin
        exp_t e;
        bit   used;
        bit   all_diff;
        e = '0;
        if (reset) begin
            m_level = '0;
            for (int b = 0; b < NB; b++) begin
                pipe0[b] = 1'b0;
                pipe1[b] = 1'b0;
                win[b].delete();
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                used     = pipe0[b];
                pipe0[b] = pipe1[b];
                pipe1[b] = ~key_raw[b];
                win[b].push_back(used);
                if (win[b].size() > D) void'(win[b].pop_front());
                if (win[b].size() == D) begin
                    all_diff = 1'b1;
                    foreach (win[b][k]) if (win[b][k] == m_level[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[b] = used;
                        if (used) e.press[b] = 1'b1;
                        else      e.rel[b]   = 1'b1;
                    end
                end
            end
        end
        e.level = m_level;
        expq.push_back(e);
    end

    // Monitor: compare the DUT against the oldest prediction on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty at %0t: actual=0 entries expected>=1", $time);
        end else begin
            e = expq.pop_front();
            chk("level",   btn_level,   e.level);
            chk("press",   btn_press,   e.press);
            chk("release", btn_release, e.rel);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for edge 9 after an input change made at a falling edge, then sample.
    task automatic to_edge9();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all keys released, then idle.
        reset   = 1'b1;
        key_raw = 4'b1111;
        step(3);
        reset = 1'b0;
        step(20);
        chk("idle_level", btn_level, 4'b0000);

        // Clean press and release on bit 0.
        key_raw = 4'b1110;
        to_edge9();
        chk("press0_level", btn_level, 4'b0001);
        chk("press0_pulse", btn_press, 4'b0001);
        @(posedge clk); #1;
        chk("press0_pulse_end", btn_press, 4'b0000);
        step(5);
        key_raw = 4'b1111;
        to_edge9();
        chk("rel0_level", btn_level, 4'b0000);
        chk("rel0_pulse", btn_release, 4'b0001);
        step(5);

        // Bounce on bit 1: 3-cycle periods for 30 cycles, then held low.
        for (int i = 0; i < 30; i++) begin
            key_raw[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        key_raw[1] = 1'b0;
        to_edge9();
        chk("bounce_level", btn_level, 4'b0010);
        chk("bounce_pulse", btn_press, 4'b0010);
        step(3);
        key_raw = 4'b1111;
        step(15);

        // Near-miss on bit 2: 7 low cycles, then 1 high, then a full hold.
        key_raw[2] = 1'b0;
        step(7);
        key_raw[2] = 1'b1;
        step(1);
        key_raw[2] = 1'b0;
        to_edge9();
        chk("nearmiss_level", btn_level, 4'b0100);
        chk("nearmiss_pulse", btn_press, 4'b0100);
        step(3);
        key_raw = 4'b1111;
        step(15);

        // All four buttons at once.
        key_raw = 4'b0000;
        to_edge9();
        chk("simul_level", btn_level, 4'b1111);
        chk("simul_pulse", btn_press, 4'b1111);
        step(3);
        key_raw = 4'b1111;
        to_edge9();
        chk("simul_rel", btn_release, 4'b1111);
        step(5);

        // Reset 5 cycles into a press on bit 3, key kept held.
        key_raw[3] = 1'b0;
        step(5);
        reset = 1'b1;
        step(3);
        chk("midreset_level", btn_level, 4'b0000);
        reset = 1'b0;
        to_edge9();
        chk("midreset_press_level", btn_level, 4'b1000);
        chk("midreset_press_pulse", btn_press, 4'b1000);
        step(3);
        key_raw = 4'b1111;
        step(15);

        // Randomised holds of random patterns with occasional resets.
        for (int i = 0; i < 400; i++) begin
            key_raw = NB'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end
            step($urandom_range(1, 14));
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
